wm_phase_timer: RTL



---
 rtl/wm_pkg.sv | 44 ++++
 rtl/wm_down_counter.sv | 36 +++
 rtl/wm_phase_timer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared phase/state encodings and default durations for the wash machine
package wm_pkg;

  typedef enum logic [2:0] {
    PH_NONE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_HEAT  = 3'd2,
    PH_SOAK  = 3'd3,
    PH_WASH  = 3'd4,
    PH_RINSE = 3'd5,
    PH_SPIN  = 3'd6
  } phase_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_HEAT  = 3'd2,
    S_FULL  = 3'd3,
    S_RUN   = 3'd4,
    S_HOLD  = 3'd5,
    S_FAULT = 3'd6
  } timer_state_e;

  localparam int DEF_FILL_CYCLES  = 16;
  localparam int DEF_HEAT_CYCLES  = 8;
  localparam int DEF_SOAK_CYCLES  = 32;
  localparam int DEF_WASH_CYCLES  = 64;
  localparam int DEF_RINSE_CYCLES = 32;
  localparam int DEF_SPIN_CYCLES  = 24;

  // ops = {soak, wash, rinse, spin}; anything but a single set bit maps to PH_NONE
  function automatic phase_e op_to_phase(input logic [3:0] ops);
    phase_e ph;
    case (ops)
      4'b1000: ph = PH_SOAK;
      4'b0100: ph = PH_WASH;
      4'b0010: ph = PH_RINSE;
      4'b0001: ph = PH_SPIN;
      default: ph = PH_NONE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/wm_down_counter.sv
// rtl/wm_down_counter.sv - loadable down counter that saturates at zero
module wm_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/wm_phase_timer.sv
// rtl/wm_phase_timer.sv - plant-side phase timer answering the wash controller's commands
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int FILL_CYCLES  = DEF_FILL_CYCLES,
  parameter int HEAT_CYCLES  = DEF_HEAT_CYCLES,
  parameter int SOAK_CYCLES  = DEF_SOAK_CYCLES,
  parameter int WASH_CYCLES  = DEF_WASH_CYCLES,
  parameter int RINSE_CYCLES = DEF_RINSE_CYCLES,
  parameter int SPIN_CYCLES  = DEF_SPIN_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             lid,
  input  logic             cancel,
  input  logic             water_Intake,
  input  logic             soak_Operation,
  input  logic             wash_Operation,
  input  logic             rinse_Operation,
  input  logic             spin_Operation,
  output logic             fill_Water,
  output logic             heat_Water,
  output logic             wash,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] remaining,
  output logic             timer_Fault
);

  localparam logic [CNT_W-1:0] FILL_LD = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] HEAT_LD = CNT_W'(HEAT_CYCLES - 1);

  function automatic logic [CNT_W-1:0] run_load(input phase_e ph);
    case (ph)
      PH_SOAK:  return CNT_W'(SOAK_CYCLES - 1);
      PH_WASH:  return CNT_W'(WASH_CYCLES - 1);
      PH_RINSE: return CNT_W'(RINSE_CYCLES - 1);
      PH_SPIN:  return CNT_W'(SPIN_CYCLES - 1);
      default:  return '0;
    endcase
  endfunction

  timer_state_e     state_q, state_d;
  phase_e           run_ph_q, run_ph_d;
  logic             ld, dec, cnt_zero;
  logic [CNT_W-1:0] ld_val, cnt;
  logic [4:0]       cmd;
  logic             fault_det;
  phase_e           req_ph;

  assign cmd       = {water_Intake, soak_Operation, wash_Operation, rinse_Operation, spin_Operation};
  assign fault_det = ((cmd & (cmd - 5'd1)) != 5'd0) || (spin_Operation && lid);
  assign req_ph    = op_to_phase(cmd[3:0]);

  wm_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (ld),
    .load_val_i (ld_val),
    .dec_i      (dec),
    .count_o    (cnt),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      run_ph_q <= PH_NONE;
    end else begin
      state_q  <= state_d;
      run_ph_q <= run_ph_d;
    end
  end

  // Leaving a timed state always loads zero so an idle counter reads 0.
  always_comb begin
    state_d  = state_q;
    run_ph_d = run_ph_q;
    ld       = 1'b0;
    ld_val   = '0;
    dec      = 1'b0;
    if (cancel) begin
      state_d  = S_IDLE;
      run_ph_d = PH_NONE;
      ld       = 1'b1;
    end else if (fault_det) begin
      state_d  = S_FAULT;
      run_ph_d = PH_NONE;
      ld       = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (water_Intake) begin
            state_d = S_FILL;
            ld      = 1'b1;
            ld_val  = FILL_LD;
          end else if (req_ph != PH_NONE) begin
            state_d  = S_RUN;
            run_ph_d = req_ph;
            ld       = 1'b1;
            ld_val   = run_load(req_ph);
          end
        end
        S_FILL, S_HEAT: begin
          if (!water_Intake) begin
            state_d = S_IDLE;
            ld      = 1'b1;
          end else if (cnt_zero) begin
            state_d = (state_q == S_FILL) ? S_HEAT : S_FULL;
            ld      = 1'b1;
            ld_val  = (state_q == S_FILL) ? HEAT_LD : '0;
          end else begin
            dec = 1'b1;
          end
        end
        S_FULL: begin
          if (!water_Intake) state_d = S_IDLE;
        end
        S_RUN: begin
          if (req_ph == PH_NONE) begin
            state_d  = S_IDLE;
            run_ph_d = PH_NONE;
            ld       = 1'b1;
          end else if (req_ph != run_ph_q) begin
            run_ph_d = req_ph;
            ld       = 1'b1;
            ld_val   = run_load(req_ph);
          end else if (cnt_zero) begin
            state_d = S_HOLD;
          end else begin
            dec = 1'b1;
          end
        end
        S_HOLD: begin
          if (req_ph != run_ph_q) begin
            state_d  = S_IDLE;
            run_ph_d = PH_NONE;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: begin
          state_d  = S_IDLE;
          run_ph_d = PH_NONE;
          ld       = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    fill_Water  = (state_q == S_HEAT) || (state_q == S_FULL);
    heat_Water  = (state_q == S_FULL);
    wash        = (state_q == S_RUN) && cnt_zero && (req_ph == run_ph_q);
    timer_Fault = (state_q == S_FAULT);
    phase       = PH_NONE;
    remaining   = '0;
    case (state_q)
      S_FILL: begin phase = PH_FILL; remaining = cnt; end
      S_HEAT: begin phase = PH_HEAT; remaining = cnt; end
      S_RUN:  begin phase = run_ph_q; remaining = cnt; end
      S_HOLD: phase = run_ph_q;
      default: ;
    endcase
  end

endmodule
